fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Control FSM for the IF stage of the 32-bit pipeline.
- Generates PCWrite, hzdetect, flush, freeze and PCSrc for the program counter, PC mux and IF/ID register.
- Sequences boot (start-address load), load-use stalls, taken-branch flushes and halt/resume.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- LOAD_STALL, 1, cycles IF is frozen per load-use hazard (1..15).
- FLUSH_CYCLES, 1, cycles IF/ID is flushed per taken branch (1..15).
- CNT_W, 16, width of the event counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_rs  input  5  rs of the instruction in ID.
- id_rt  input  5  rt of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_memread  input  1  instruction in EX is a load.
- ex_rt  input  5  destination register of the load in EX.
- branch_taken  input  1  taken branch resolved this cycle.
- halt_req  input  1  request to halt fetch.
- resume  input  1  release from HALT.
- PCWrite  output  1  PC load enable.
- hzdetect  output  1  hazard indication to the PC/ID stage.
- flush  output  1  clear IF/ID to NOP.
- freeze  output  1  hold IF/ID contents.
- PCSrc  output  2  PC mux select: 00 = PC+4, 01 = start address, 10 = branch address.
- state_o  output  3  current state: BOOT=0, RUN=1, STALL=2, FLUSH=3, HALT=4.
- stall_count  output  CNT_W  load-use events, saturating.
- flush_count  output  CNT_W  taken-branch events, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT; internal down-counter cnt=0; stall_count=0; flush_count=0.
  - While rst is low, outputs are forced: PCWrite=0, hzdetect=0, flush=1, freeze=0, PCSrc=01.
- Outputs are combinational from state and current inputs. State and counters update on the rising clk edge.
- Hazard definition: hz = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))). Register 0 never hazards.
- BOOT:
  - Outputs: PCSrc=01, PCWrite=1, flush=1.
  - Next state: RUN, unconditionally. All inputs are ignored.
- RUN, priority branch_taken > hz > halt_req:
  - branch_taken: PCSrc=10, PCWrite=1, flush=1; flush_count increments. Next state is FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  - hz: PCWrite=0, hzdetect=1, freeze=1; stall_count increments. Next state is STALL with cnt=LOAD_STALL-1 if LOAD_STALL>1, else RUN.
  - halt_req: PCWrite=0, freeze=1. Next state is HALT.
  - None of the above: PCSrc=00, PCWrite=1, flush=0, freeze=0.
- STALL:
  - Outputs: PCWrite=0, hzdetect=1, freeze=1. cnt decrements each cycle; return to RUN when cnt==0 at the clock edge.
  - branch_taken in STALL overrides: outputs become the RUN branch outputs, stall is aborted, and the FLUSH sequence starts.
- FLUSH:
  - Outputs: PCSrc=00, PCWrite=1, flush=1. cnt decrements; return to RUN when cnt==0.
  - A new branch_taken in FLUSH re-issues PCSrc=10, reloads cnt, and increments flush_count.
  - hz is ignored in FLUSH (the ID instruction is being killed).
- HALT:
  - Outputs: PCWrite=0, freeze=1, flush=0, PCSrc=00.
  - resume=1 moves to RUN on the next edge; halt_req is ignored while in HALT.
  - branch_taken in HALT is ignored; it must be resolved before the halt is requested.
- Counters saturate at all-ones with no wrap. Counting applies only in the cycle the event is accepted.
- Invalid state encodings recover to RUN on the next edge with RUN outputs.
- Reset mid-STALL/FLUSH/HALT aborts immediately; the sequence restarts from BOOT after rst deasserts.
- flush and freeze are never both 1 outside reset.

Test Plan:
- Reset release -> cycle 0 state_o=0, PCSrc=01, PCWrite=1, flush=1; cycle 1 state_o=1, PCSrc=00, PCWrite=1; counters 0.
- ex_memread=1, ex_rt=5, id_rs=5 in RUN with LOAD_STALL=3 -> PCWrite=0, freeze=1, hzdetect=1 for exactly 3 cycles, then PCWrite=1; stall_count=1. Repeat with ex_rt=0 -> no stall.
- branch_taken=1 with FLUSH_CYCLES=2 -> cycle 0 PCSrc=10, flush=1; cycle 1 PCSrc=00, flush=1; cycle 2 flush=0; flush_count=1.
- branch_taken and hz asserted together in RUN -> branch wins: PCSrc=10, hzdetect=0, stall_count unchanged.
- halt_req=1 -> next cycle state_o=4, PCWrite=0, freeze=1; hold 10 cycles; resume=1 -> state_o=1 next cycle.
- rst pulled low mid-STALL -> outputs immediately take reset values; after release, BOOT is repeated.
- Saturation: with CNT_W=4, 20 hazards -> stall_count=15.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the hazard/branch/halt inputs and the PC / IF-ID control outputs
//   of the IF-stage fetch sequencer.
//
//   Signalling: there is no valid/ready pairing here. Every input is a level
//   that the sequencer samples on each rising clk edge; every output is a
//   combinational level valid for the whole current cycle.
//
//   Modports:
//     master : the sequencer (consumes hazard/branch/halt, drives controls)
//     slave  : the pipeline side (drives hazard/branch/halt, consumes controls)
//
//   Signals:
//     id_rs, id_rt, id_uses_rt   source registers of the instruction in ID
//     ex_memread, ex_rt          load in EX and its destination register
//     branch_taken               taken branch resolved this cycle
//     halt_req, resume           halt request / release from halt
//     PCWrite, hzdetect          PC load enable, hazard indication
//     flush, freeze              clear IF/ID to NOP, hold IF/ID
//     PCSrc                      PC mux select (00 PC+4, 01 start, 10 branch)
//     state_o                    current sequencer state (debug)
//     stall_count, flush_count   saturating event counters (debug)
// ----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             halt_req;
    logic             resume;
    logic             PCWrite;
    logic             hzdetect;
    logic             flush;
    logic             freeze;
    logic [1:0]       PCSrc;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               branch_taken, halt_req, resume,
        output PCWrite, hzdetect, flush, freeze, PCSrc,
               state_o, stall_count, flush_count
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               branch_taken, halt_req, resume,
        input  PCWrite, hzdetect, flush, freeze, PCSrc,
               state_o, stall_count, flush_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//   Control FSM for the IF stage. Sequences boot (start-address load),
//   load-use stalls, taken-branch flushes and halt/resume, and keeps
//   saturating stall/flush event counters for debug.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous, active-low reset
//     bus  : fetch_sequencer_if.master (inputs, controls, debug state/counters)
//
//   Parameters:
//     LOAD_STALL   : cycles IF is frozen per load-use hazard (1..15)
//     FLUSH_CYCLES : cycles IF/ID is flushed per taken branch (1..15)
//     CNT_W        : event counter width
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_START  = 2'b01;
    localparam logic [1:0] SRC_BRANCH = 2'b10;

    // The cycle that detects the event is itself the first stall/flush cycle,
    // so the dedicated state only has to cover the remaining N-1 cycles.
    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL - 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;
    logic             hz;

    logic             pc_write, hz_out, flush_out, freeze_out;
    logic [1:0]       pc_src;

    // Load-use hazard; register 0 is hard-wired and never hazards.
    assign hz = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                ((bus.ex_rt == bus.id_rs) ||
                 (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    // ------------------------------------------------------------------
    // State register and down-counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        pc_write   = 1'b0;
        hz_out     = 1'b0;
        flush_out  = 1'b0;
        freeze_out = 1'b0;
        pc_src     = SRC_SEQ;

        unique case (state_q)
            BOOT: begin
                pc_src    = SRC_START;
                pc_write  = 1'b1;
                flush_out = 1'b1;
                state_d   = RUN;
            end

            RUN: begin
                if (bus.branch_taken) begin
                    pc_src    = SRC_BRANCH;
                    pc_write  = 1'b1;
                    flush_out = 1'b1;
                    flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else if (hz) begin
                    hz_out     = 1'b1;
                    freeze_out = 1'b1;
                    stall_inc  = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = STALL;
                        cnt_d   = STALL_RELOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else if (bus.halt_req) begin
                    freeze_out = 1'b1;
                    state_d    = HALT;
                end else begin
                    pc_write = 1'b1;
                end
            end

            STALL: begin
                if (bus.branch_taken) begin
                    // A resolved branch kills the stalled instruction anyway.
                    pc_src    = SRC_BRANCH;
                    pc_write  = 1'b1;
                    flush_out = 1'b1;
                    flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end else begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    hz_out     = 1'b1;
                    freeze_out = 1'b1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            FLUSH: begin
                pc_write  = 1'b1;
                flush_out = 1'b1;
                if (bus.branch_taken) begin
                    pc_src    = SRC_BRANCH;
                    flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d = FLUSH_RELOAD;
                    end else begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end
                end else if (cnt_q <= 4'd1) begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            HALT: begin
                freeze_out = 1'b1;
                if (bus.resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                // Unused encodings behave as plain RUN for one cycle.
                pc_write = 1'b1;
                state_d  = RUN;
                cnt_d    = 4'd0;
            end
        endcase

        // Reset forces the boot-time values asynchronously.
        if (!rst) begin
            pc_write   = 1'b0;
            hz_out     = 1'b0;
            flush_out  = 1'b1;
            freeze_out = 1'b0;
            pc_src     = SRC_START;
            stall_inc  = 1'b0;
            flush_inc  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.hzdetect    = hz_out;
    assign bus.flush       = flush_out;
    assign bus.freeze      = freeze_out;
    assign bus.PCSrc       = pc_src;
    assign bus.state_o     = state_q;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer with LOAD_STALL=3, FLUSH_CYCLES=2,
//   CNT_W=4. The driver applies inputs just after each rising edge and pushes
//   the hand-computed expected outputs for that cycle; the monitor pops and
//   compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int W = 17;

    logic clk;
    logic rst;

    fetch_sequencer_if #(.CNT_W(4)) bus ();

    fetch_sequencer #(
        .LOAD_STALL  (3),
        .FLUSH_CYCLES(2),
        .CNT_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_vec  = 0;
    int           n_fail = 0;

    // Expected counter values tracked by the driver.
    logic [3:0] sc_m;
    logic [3:0] fc_m;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {bus.state_o, bus.PCWrite, bus.hzdetect, bus.flush, bus.freeze,
                  bus.PCSrc, bus.stall_count, bus.flush_count};
            n_vec++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got st=%0d pw=%b hz=%b fl=%b fr=%b src=%b sc=%0d fc=%0d, want st=%0d pw=%b hz=%b fl=%b fr=%b src=%b sc=%0d fc=%0d",
                         nm, a[16:14], a[13], a[12], a[11], a[10], a[9:8], a[7:4], a[3:0],
                         e[16:14], e[13], e[12], e[11], e[10], e[9:8], e[7:4], e[3:0]);
            end
            if (rst && bus.flush && bus.freeze) begin
                n_fail++;
                $display("FAIL %s_flush_freeze: got flush=1 freeze=1, want not both", nm);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_cycle(input logic [2:0] st, input logic pw, input logic hzd,
                                input logic fl, input logic fr, input logic [1:0] src,
                                input string nm);
        exp_q.push_back({st, pw, hzd, fl, fr, src, sc_m, fc_m});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_rt        = 5'd0;
        bus.branch_taken = 1'b0;
        bus.halt_req     = 1'b0;
        bus.resume       = 1'b0;
    endtask

    task automatic set_hazard(input logic [4:0] rt);
        bus.ex_memread = 1'b1;
        bus.ex_rt      = rt;
        bus.id_rs      = rt;
    endtask

    task automatic sat_inc_sc();
        if (sc_m != 4'hF) sc_m = sc_m + 4'd1;
    endtask

    task automatic sat_inc_fc();
        if (fc_m != 4'hF) fc_m = fc_m + 4'd1;
    endtask

    // Hazard in RUN followed by the two remaining STALL cycles.
    task automatic full_stall(input string nm);
        set_hazard(5'd5);
        expect_cycle(3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, {nm, "_detect"});
        sat_inc_sc();
        clear_inputs();
        expect_cycle(3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, {nm, "_stall1"});
        expect_cycle(3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, {nm, "_stall2"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst  = 1'b0;
        sc_m = 4'd0;
        fc_m = 4'd0;
        clear_inputs();
        @(posedge clk);
        #1;

        // Reset values while rst is low
        expect_cycle(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, "reset_hold");
        rst = 1'b1;
        expect_cycle(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, "boot");
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "run_first");

        // Load-use stall via rs: exactly 3 frozen cycles
        full_stall("ld_rs");
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "ld_rs_release");

        // ex_rt = 0 never hazards
        bus.ex_memread = 1'b1;
        bus.ex_rt      = 5'd0;
        bus.id_rs      = 5'd0;
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "ld_r0_nostall");
        clear_inputs();

        // rt match without id_uses_rt: no hazard
        bus.ex_memread = 1'b1;
        bus.ex_rt      = 5'd7;
        bus.id_rt      = 5'd7;
        bus.id_rs      = 5'd3;
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "ld_rt_unused");

        // rt match with id_uses_rt: hazard
        bus.id_uses_rt = 1'b1;
        expect_cycle(3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "ld_rt_detect");
        sat_inc_sc();
        clear_inputs();
        expect_cycle(3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "ld_rt_stall1");
        expect_cycle(3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "ld_rt_stall2");
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "ld_rt_release");

        // Taken branch, FLUSH_CYCLES = 2
        bus.branch_taken = 1'b1;
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, "br_issue");
        sat_inc_fc();
        clear_inputs();
        expect_cycle(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "br_flush");
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "br_done");

        // Branch and hazard together: branch wins, no stall counted
        bus.branch_taken = 1'b1;
        set_hazard(5'd9);
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, "br_hz_issue");
        sat_inc_fc();
        bus.branch_taken = 1'b0;
        // hazard still present in FLUSH is ignored
        expect_cycle(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "br_hz_flush");
        clear_inputs();
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "br_hz_done");

        // Re-issued branch inside FLUSH reloads the count
        bus.branch_taken = 1'b1;
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, "br2_issue");
        sat_inc_fc();
        expect_cycle(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, "br2_reissue");
        sat_inc_fc();
        clear_inputs();
        expect_cycle(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "br2_flush");
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "br2_done");

        // Branch during STALL aborts the stall
        set_hazard(5'd4);
        expect_cycle(3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "stbr_detect");
        sat_inc_sc();
        clear_inputs();
        bus.branch_taken = 1'b1;
        expect_cycle(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, "stbr_branch");
        sat_inc_fc();
        clear_inputs();
        expect_cycle(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "stbr_flush");
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "stbr_done");

        // Halt, hold 10 cycles (branch/halt_req ignored), resume
        bus.halt_req = 1'b1;
        expect_cycle(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "halt_req");
        for (int i = 0; i < 10; i++) begin
            bus.branch_taken = (i == 3);
            expect_cycle(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, $sformatf("halt_hold%0d", i));
        end
        clear_inputs();
        bus.resume = 1'b1;
        expect_cycle(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "halt_resume");
        clear_inputs();
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "halt_out");

        // Reset in the middle of a STALL
        set_hazard(5'd6);
        expect_cycle(3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "rst_detect");
        sat_inc_sc();
        clear_inputs();
        expect_cycle(3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "rst_stall1");
        rst  = 1'b0;
        sc_m = 4'd0;
        fc_m = 4'd0;
        expect_cycle(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, "rst_mid_stall");
        rst = 1'b1;
        expect_cycle(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, "reboot");
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "reboot_run");

        // Saturation: 20 hazards on a 4-bit counter end at 15
        for (int i = 0; i < 20; i++) begin
            full_stall($sformatf("sat%0d", i));
        end
        expect_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "sat_final");
        if (sc_m != 4'd15) begin
            n_fail++;
            $display("FAIL sat_model: got %0d, want 15", sc_m);
        end

        // Let the monitor drain, bounded
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
